// File: rtl/spi_axi_regbridge_if.sv
// AXI4 slave-side bundle for the register bridge: AW, W, B, AR and R channels.
// Every channel uses valid/ready: a beat transfers on a rising clock edge where both are high.
interface spi_axi_regbridge_if #(
  parameter int DW  = 128,
  parameter int AW  = 32,
  parameter int IDW = 6
);
  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/spi_axi_regbridge.sv
// Single-beat AXI4 register accesses turned into one-byte-at-a-time requests
// toward NCH QSPI controller register ports, with one transaction in flight.
module spi_axi_regbridge #(
  parameter int DW      = 128,
  parameter int AW      = 32,
  parameter int IDW     = 6,
  parameter int NCH     = 2,
  parameter int WIN_LSB = 12,
  parameter logic [AW-WIN_LSB-1:0] WIN_BASE = 'h1fff0,
  localparam int LB     = $clog2(DW/8)
) (
  input  logic                aclk,
  input  logic                areset,
  spi_axi_regbridge_if.slave  bus,
  output logic [NCH-1:0]      req_vld,
  input  logic [NCH-1:0]      req_rdy,
  output logic [LB-1:0]       req_addr,
  output logic                req_read,
  output logic [7:0]          req_dat,
  input  logic [NCH-1:0]      rsp_vld,
  output logic [NCH-1:0]      rsp_rdy,
  input  logic [NCH*8-1:0]    rsp_dat,
  output logic [3:0]          dbg_state
);

  localparam int NB  = DW / 8;
  localparam int CW  = WIN_LSB - LB;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_WDRAIN, S_WREQ, S_WRSP, S_BRESP, S_RREQ, S_RRSP, S_RERR, S_RRESP
  } state_t;

  state_t          state, state_n;
  logic            ptr, ptr_n;
  logic [IDW-1:0]  id_q, id_n;
  logic [CHW-1:0]  ch_q, ch_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic [NB-1:0]   mask_q, mask_n;
  logic [1:0]      resp_q, resp_n;
  logic [DW-1:0]   rbuf_q, rbuf_n;
  logic [LB-1:0]   lane_q, lane_n;
  logic [LB:0]     cnt_q, cnt_n;
  logic [LB:0]     nb_q, nb_n;
  logic [7:0]      beats_q, beats_n;

  logic [LB-1:0]   low_lane;
  logic [LB:0]     rd_nb, rd_nbm1;
  logic            wr_cand, rd_cand, grant_w, grant_r;
  logic            unused_bits;

  assign unused_bits = ^{bus.awsize, bus.awaddr[LB-1:0]};

  function automatic logic [CHW-1:0] ch_of(input logic [AW-1:0] a);
    logic [CW-1:0] c;
    c = a[WIN_LSB-1:LB];
    return c[CHW-1:0];
  endfunction

  function automatic logic is_mapped(input logic [AW-1:0] a);
    return (a[AW-1:WIN_LSB] == WIN_BASE) && (32'(a[WIN_LSB-1:LB]) < NCH);
  endfunction

  always_comb begin
    low_lane = '0;
    for (int i = NB - 1; i >= 0; i--)
      if (mask_q[i]) low_lane = LB'(i);
  end

  assign wr_cand = bus.awvalid && bus.wvalid;
  assign rd_cand = bus.arvalid;
  // ptr == 0 favours the write when both channels are waiting.
  assign grant_w = wr_cand && (!rd_cand || !ptr);
  assign grant_r = rd_cand && (!wr_cand || ptr);
  assign rd_nb   = (LB+1)'(1) << bus.arsize;
  assign rd_nbm1 = rd_nb - (LB+1)'(1);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    id_n    = id_q;
    ch_n    = ch_q;
    wdata_n = wdata_q;
    mask_n  = mask_q;
    resp_n  = resp_q;
    rbuf_n  = rbuf_q;
    lane_n  = lane_q;
    cnt_n   = cnt_q;
    nb_n    = nb_q;
    beats_n = beats_q;

    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = id_q;
    bus.bresp   = resp_q;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rid     = id_q;
    bus.rdata   = '0;
    bus.rresp   = resp_q;
    bus.rlast   = 1'b0;
    req_vld     = '0;
    req_addr    = lane_q;
    req_read    = 1'b0;
    req_dat     = '0;
    rsp_rdy     = '0;

    unique case (state)
      S_IDLE: begin
        if (wr_cand && rd_cand) ptr_n = !ptr;
        if (grant_w) begin
          bus.awready = 1'b1;
          bus.wready  = (bus.awlen == 8'd0);
          id_n    = bus.awid;
          ch_n    = ch_of(bus.awaddr);
          wdata_n = bus.wdata;
          mask_n  = bus.wstrb;
          resp_n  = RESP_OKAY;
          // Bursts are drained before answering; the decode error wins over the burst error.
          if (bus.awlen != 8'd0) begin
            resp_n  = is_mapped(bus.awaddr) ? RESP_SLVERR : RESP_DECERR;
            state_n = S_WDRAIN;
          end else if (!is_mapped(bus.awaddr)) begin
            resp_n  = RESP_DECERR;
            state_n = S_BRESP;
          end else if (bus.wstrb == '0) begin
            state_n = S_BRESP;
          end else begin
            state_n = S_WREQ;
          end
        end else if (grant_r) begin
          bus.arready = 1'b1;
          id_n    = bus.arid;
          ch_n    = ch_of(bus.araddr);
          beats_n = bus.arlen;
          nb_n    = rd_nb;
          lane_n  = bus.araddr[LB-1:0] & ~rd_nbm1[LB-1:0];
          cnt_n   = '0;
          rbuf_n  = '0;
          resp_n  = RESP_OKAY;
          if (!is_mapped(bus.araddr)) begin
            resp_n  = RESP_DECERR;
            state_n = S_RERR;
          end else if (bus.arlen != 8'd0 || 32'(bus.arsize) > LB) begin
            resp_n  = RESP_SLVERR;
            state_n = S_RERR;
          end else begin
            state_n = S_RREQ;
          end
        end
      end
      S_WDRAIN: begin
        bus.wready = 1'b1;
        if (bus.wvalid && bus.wlast) state_n = S_BRESP;
      end
      S_WREQ: begin
        req_vld[ch_q] = 1'b1;
        req_addr      = low_lane;
        req_dat       = wdata_q[{low_lane, 3'b000} +: 8];
        if (req_rdy[ch_q]) begin
          lane_n  = low_lane;
          state_n = S_WRSP;
        end
      end
      S_WRSP: begin
        rsp_rdy[ch_q] = 1'b1;
        if (rsp_vld[ch_q]) begin
          mask_n  = mask_q & ~(NB'(1) << lane_q);
          state_n = (mask_n == '0) ? S_BRESP : S_WREQ;
        end
      end
      S_BRESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) state_n = S_IDLE;
      end
      S_RREQ: begin
        req_vld[ch_q] = 1'b1;
        req_read      = 1'b1;
        if (req_rdy[ch_q]) state_n = S_RRSP;
      end
      S_RRSP: begin
        rsp_rdy[ch_q] = 1'b1;
        if (rsp_vld[ch_q]) begin
          rbuf_n[{lane_q, 3'b000} +: 8] = rsp_dat[{ch_q, 3'b000} +: 8];
          cnt_n = cnt_q + (LB+1)'(1);
          if (cnt_n == nb_q) begin
            state_n = S_RRESP;
          end else begin
            lane_n  = lane_q + LB'(1);
            state_n = S_RREQ;
          end
        end
      end
      S_RERR: begin
        bus.rvalid = 1'b1;
        bus.rlast  = (beats_q == 8'd0);
        if (bus.rready) begin
          if (beats_q == 8'd0) state_n = S_IDLE;
          else beats_n = beats_q - 8'd1;
        end
      end
      S_RRESP: begin
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        bus.rdata  = rbuf_q;
        if (bus.rready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= S_IDLE;
      ptr     <= 1'b0;
      id_q    <= '0;
      ch_q    <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      resp_q  <= '0;
      rbuf_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
      beats_q <= '0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      id_q    <= id_n;
      ch_q    <= ch_n;
      wdata_q <= wdata_n;
      mask_q  <= mask_n;
      resp_q  <= resp_n;
      rbuf_q  <= rbuf_n;
      lane_q  <= lane_n;
      cnt_q   <= cnt_n;
      nb_q    <= nb_n;
      beats_q <= beats_n;
    end
  end

endmodule

// File: tb/tb_spi_axi_regbridge.sv
// Directed bench for spi_axi_regbridge: expected requests and responses are queued at issue
// time and checked by a monitor against what the bridge presents downstream and on B/R.
module tb_spi_axi_regbridge;
  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int IDW   = 6;
  localparam int NCH   = 2;
  localparam int LB    = 4;
  localparam int REQ_W = NCH + 1 + LB + 8;
  localparam int RSP_W = 1 + IDW + 2 + 1 + DW;

  logic              aclk = 1'b0;
  logic              areset;
  logic [NCH-1:0]    req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [LB-1:0]     req_addr;
  logic              req_read;
  logic [7:0]        req_dat;
  logic [NCH*8-1:0]  rsp_dat;
  logic [3:0]        dbg_state;

  spi_axi_regbridge_if #(.DW(DW), .AW(AW), .IDW(IDW)) bus ();

  spi_axi_regbridge dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_addr  (req_addr),
    .req_read  (req_read),
    .req_dat   (req_dat),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_dat   (rsp_dat),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [REQ_W-1:0] exp_req_q[$];
  logic [RSP_W-1:0] exp_q[$];
  logic [REQ_W-1:0] mon_req, mon_req_exp;
  logic [RSP_W-1:0] mon_rsp, mon_rsp_exp;
  int               checks = 0;
  int               errors = 0;
  logic             hold_rsp = 1'b0;
  logic [7:0]       rd_mem [NCH][16];

  task automatic push_req(input int ch, input logic rd, input logic [LB-1:0] a, input logic [7:0] d);
    exp_req_q.push_back({NCH'(1 << ch), rd, a, d});
  endtask

  task automatic push_b(input logic [IDW-1:0] id, input logic [1:0] resp);
    exp_q.push_back({1'b0, id, resp, 1'b0, {DW{1'b0}}});
  endtask

  task automatic push_r(input logic [IDW-1:0] id, input logic [1:0] resp, input logic last,
                        input logic [DW-1:0] data);
    exp_q.push_back({1'b1, id, resp, last, data});
  endtask

  task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge aclk);
    if (areset !== 1'b1) begin
      if ((req_vld & req_rdy) != '0) begin
        mon_req = {req_vld, req_read, req_addr, req_dat};
        checks++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: got %h required none", mon_req);
        end else begin
          mon_req_exp = exp_req_q.pop_front();
          if (mon_req !== mon_req_exp) begin
            errors++;
            $display("FAIL req: got %h required %h", mon_req, mon_req_exp);
          end
        end
      end
      if (bus.bvalid && bus.bready) begin
        mon_rsp = {1'b0, bus.bid, bus.bresp, 1'b0, {DW{1'b0}}};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got %h required none", mon_rsp);
        end else begin
          mon_rsp_exp = exp_q.pop_front();
          if (mon_rsp !== mon_rsp_exp) begin
            errors++;
            $display("FAIL b_resp: got %h required %h", mon_rsp, mon_rsp_exp);
          end
        end
      end
      if (bus.rvalid && bus.rready) begin
        mon_rsp = {1'b1, bus.rid, bus.rresp, bus.rlast, bus.rdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got %h required none", mon_rsp);
        end else begin
          mon_rsp_exp = exp_q.pop_front();
          if (mon_rsp !== mon_rsp_exp) begin
            errors++;
            $display("FAIL r_beat: got %h required %h", mon_rsp, mon_rsp_exp);
          end
        end
      end
    end
  end

  // ---------------- downstream controller model ----------------
  initial begin
    int         phase;
    int         c;
    int         dly;
    logic       rdy_set;
    logic [3:0] a;
    req_rdy = '0; rsp_vld = '0; rsp_dat = '0;
    phase = 0; c = 0; dly = 0; rdy_set = 1'b0; a = '0;
    forever begin
      @(posedge aclk); #1;
      if (areset === 1'b1) begin
        req_rdy = '0; rsp_vld = '0; rsp_dat = '0; phase = 0; rdy_set = 1'b0;
      end else if (phase == 0) begin
        if (rdy_set) begin
          req_rdy = '0; rdy_set = 1'b0; phase = 1; dly = $urandom_range(0, 2);
        end else if (req_vld != '0 && $urandom_range(0, 2) != 0) begin
          c = req_vld[1] ? 1 : 0;
          a = req_addr;
          req_rdy[c] = 1'b1;
          rdy_set = 1'b1;
        end
      end else begin
        if (rsp_vld != '0) begin
          rsp_vld = '0; rsp_dat = '0; phase = 0;
        end else if (dly > 0) begin
          dly--;
        end else if (!hold_rsp) begin
          rsp_vld[c] = 1'b1;
          rsp_dat[c*8 +: 8] = rd_mem[c][a];
          // The idle channel chatters too; the bridge must not take its byte.
          rsp_vld[1-c] = 1'b1;
          rsp_dat[(1-c)*8 +: 8] = 8'hEE;
        end
      end
    end
  end

  initial begin
    bus.bready = 1'b0; bus.rready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      bus.bready = ($urandom_range(0, 3) != 0);
      bus.rready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [DW/8-1:0] strb, input logic [DW-1:0] data);
    logic aw_done, w_done, aw_hs, w_hs;
    int   beat, n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd4; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wlast = (len == 8'd0); bus.wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; beat = 0; n = 0;
    while (!(aw_done && w_done)) begin
      @(negedge aclk);
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs) begin
        if (bus.wlast) begin
          bus.wvalid = 1'b0; bus.wlast = 1'b0; w_done = 1'b1;
        end else begin
          beat++;
          bus.wlast = (beat == int'(len));
        end
      end
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL write_handshake id %0d: got no completion after %0d cycles, required within 500", id, n);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        break;
      end
    end
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size);
    logic hs, done;
    int   n;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arvalid = 1'b1;
    done = 1'b0; n = 0;
    while (!done) begin
      @(negedge aclk);
      hs = bus.arvalid && bus.arready;
      @(posedge aclk); #1;
      if (hs) begin bus.arvalid = 1'b0; done = 1'b1; end
      n++;
      if (!done && n > 500) begin
        checks++; errors++;
        $display("FAIL read_handshake id %0d: got no arready after %0d cycles, required within 500", id, n);
        bus.arvalid = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_req_q.size() != 0) && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL drain_%s: got %0d requests and %0d responses outstanding, required 0",
               tag, exp_req_q.size(), exp_q.size());
      exp_q.delete();
      exp_req_q.delete();
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ctrl"}, DW'({req_vld, req_read, req_addr, req_dat, rsp_rdy, bus.awready, bus.wready,
                                   bus.arready, bus.bvalid, bus.rvalid, bus.rlast, bus.bresp, bus.rresp}), '0);
    check_val({tag, "_rdata"}, bus.rdata, '0);
    check_val({tag, "_ids"}, DW'({bus.bid, bus.rid}), '0);
    check_val({tag, "_state"}, DW'(dbg_state), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < 16; a++)
        rd_mem[c][a] = {4'(c + 1), 4'(a)};
    rd_mem[0][4] = 8'h11; rd_mem[0][5] = 8'h22; rd_mem[0][6] = 8'h33; rd_mem[0][7] = 8'h44;

    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arvalid = 1'b0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_quiet("reset");
    @(posedge aclk); #1;
    areset = 1'b0;

    // Two strobed lanes on channel 1, issued lowest lane first.
    push_req(1, 1'b0, 4'd2, 8'hA5);
    push_req(1, 1'b0, 4'd5, 8'h3C);
    push_b(6'h2A, 2'b00);
    axi_write(6'h2A, 32'h1FFF_0010, 8'd0, 16'h0024, 128'h3C_0000_A5_0000);
    wait_drain("write_ch1");

    // Word read on channel 0: lanes 4..7 land in rdata[63:32].
    for (int a = 4; a < 8; a++) push_req(0, 1'b1, 4'(a), 8'h00);
    push_r(6'h04, 2'b00, 1'b1, 128'h0000_0000_0000_0000_4433_2211_0000_0000);
    axi_read(6'h04, 32'h1FFF_0004, 8'd0, 3'd2);
    wait_drain("read_ch0");

    // Write and read both waiting: granted write, read, write.
    push_req(0, 1'b0, 4'd0, 8'h5A);
    push_req(0, 1'b0, 4'd15, 8'hC3);
    push_b(6'h01, 2'b00);
    for (int a = 4; a < 8; a++) push_req(0, 1'b1, 4'(a), 8'h00);
    push_r(6'h02, 2'b00, 1'b1, 128'h0000_0000_0000_0000_4433_2211_0000_0000);
    push_req(1, 1'b0, 4'd8, 8'h77);
    push_b(6'h03, 2'b00);
    fork
      begin
        axi_write(6'h01, 32'h1FFF_0000, 8'd0, 16'h8001, 128'hC300_0000_0000_0000_0000_0000_0000_005A);
        axi_write(6'h03, 32'h1FFF_0010, 8'd0, 16'h0100, 128'h0000_0000_0000_0077_0000_0000_0000_0000);
      end
      axi_read(6'h02, 32'h1FFF_0006, 8'd0, 3'd2);
    join
    wait_drain("arbitration");

    // Unmapped window, four-beat burst: DECERR on every beat, rlast only on the last.
    for (int b = 0; b < 4; b++) push_r(6'h05, 2'b11, (b == 3), '0);
    axi_read(6'h05, 32'h1FFE_0000, 8'd3, 3'd4);
    wait_drain("read_unmapped");

    // Channel index beyond NCH inside the window.
    push_b(6'h06, 2'b11);
    axi_write(6'h06, 32'h1FFF_0020, 8'd0, 16'h0001, 128'h0000_00FF);
    wait_drain("write_bad_ch");

    // Two-beat write burst is drained and rejected.
    push_b(6'h07, 2'b10);
    axi_write(6'h07, 32'h1FFF_0000, 8'd1, 16'h0000, '0);
    wait_drain("write_burst");

    // Empty strobe completes without downstream traffic.
    push_b(6'h08, 2'b00);
    axi_write(6'h08, 32'h1FFF_0010, 8'd0, 16'h0000, 128'h1234);
    wait_drain("write_nostrb");

    // Size larger than the bus.
    push_r(6'h09, 2'b10, 1'b1, '0);
    axi_read(6'h09, 32'h1FFF_0000, 8'd0, 3'd5);
    wait_drain("read_oversize");

    // Single byte at an odd lane of channel 1.
    push_req(1, 1'b1, 4'd9, 8'h00);
    push_r(6'h0A, 2'b00, 1'b1, 128'h29 << 72);
    axi_read(6'h0A, 32'h1FFF_0019, 8'd0, 3'd0);
    wait_drain("read_byte");

    // Reset while a write byte waits for its response.
    hold_rsp = 1'b1;
    push_req(1, 1'b0, 4'd1, 8'h99);
    axi_write(6'h0B, 32'h1FFF_0010, 8'd0, 16'h0002, 128'h9900);
    n = 0;
    while (dbg_state != 4'd3 && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    check_val("reach_wrsp", DW'(dbg_state), DW'(4'd3));
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_quiet("midreset");
    @(posedge aclk); #1;
    areset = 1'b0;
    hold_rsp = 1'b0;
    check_val("midreset_pending", DW'(exp_req_q.size()), '0);

    push_req(1, 1'b1, 4'd14, 8'h00);
    push_req(1, 1'b1, 4'd15, 8'h00);
    push_r(6'h0C, 2'b00, 1'b1, 128'h2F2E << 112);
    axi_read(6'h0C, 32'h1FFF_001E, 8'd0, 3'd1);
    wait_drain("read_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_axi_regbridge.md
Name: spi_axi_regbridge

Overview:
- AXI4 slave that converts single-beat register accesses into serial byte requests toward NCH QSPI controller register ports.
- Generalises the single-window, single-byte QSPI register path to:
  - NCH decoded channels;
  - full multi-byte write strobes;
  - sized multi-byte reads;
  - error responses for unsupported accesses;
  - fair read/write arbitration.
- Sits between the SPI subsystem AXI port and the qspi_wrap instances.

Parameters:
- DW, 128, AXI data width (bits); LB = log2(DW/8) lane-index bits.
- AW, 32, AXI address width.
- IDW, 6, AXI ID width.
- NCH, 2, number of controller channels (1..8).
- WIN_LSB, 12, lowest address bit of the window compare; requires WIN_LSB-LB >= clog2(NCH).
- WIN_BASE, 20'h1fff0, value compared against addr[AW-1:WIN_LSB].

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- AXI AW channel (in unless noted): awid IDW, awaddr AW, awlen 8, awsize 3, awvalid 1; awready out 1.
- AXI W channel: wdata DW in, wstrb DW/8 in, wlast 1 in, wvalid 1 in; wready out 1.
- AXI B channel: bid IDW out, bresp 2 out, bvalid 1 out; bready in 1.
- AXI AR channel: arid IDW in, araddr AW in, arlen 8 in, arsize 3 in, arvalid 1 in; arready out 1.
- AXI R channel: rid IDW out, rdata DW out, rresp 2 out, rlast 1 out, rvalid 1 out; rready in 1.
- req_vld  out  NCH  one-hot byte request.
- req_rdy  in  NCH.
- req_addr  out  LB  register byte address.
- req_read  out  1.
- req_dat  out  8  write byte.
- rsp_vld  in  NCH.
- rsp_rdy  out  NCH.
- rsp_dat  in  NCH*8  channel c byte at [c*8+7:c*8].

Behaviour:
- Reset: every output, state register and byte buffer is 0; FSM = IDLE; arbitration pointer = write-first. Reset is honoured in any state; an outstanding downstream request is abandoned (req_vld drops the next cycle).
- Decode:
  - hit = addr[AW-1:WIN_LSB] == WIN_BASE;
  - ch = addr[WIN_LSB-1:LB];
  - mapped = hit & ch < NCH.
- Unmapped access returns DECERR (2'b11).
- IDLE, candidates:
  - write candidate = awvalid & wvalid;
  - read candidate = arvalid.
- IDLE, arbitration:
  - both present: the pointer selects the winner, and the pointer flips after each grant;
  - only one present: it wins and the pointer is unchanged.
- Write grant:
  - awready = 1 for one cycle;
  - wready = 1 in the same cycle only if awlen == 0;
  - latch id, ch, wdata, wstrb (pending mask).
- Write error checks:
  - awlen != 0: go to WDRAIN; hold wready = 1 until a beat with wlast is accepted, then respond SLVERR;
  - unmapped: respond DECERR;
  - wstrb == 0: respond OKAY with no downstream traffic.
- WREQ:
  - lane = lowest set bit of the pending mask;
  - drive req_vld[ch] = 1, req_read = 0, req_addr = lane, req_dat = wdata byte lane;
  - hold until req_rdy[ch], then go to WRSP.
- WRSP:
  - rsp_rdy[ch] = 1; on rsp_vld[ch], clear the lane bit from the pending mask;
  - mask now zero: go to BRESP (OKAY); otherwise return to WREQ.
  - Next request issues the cycle after the response, so there is one outstanding byte per bridge.
- BRESP: bvalid = 1 with bid/bresp stable until bready, then go to IDLE.
- Read grant:
  - arready = 1 for one cycle; latch id, ch, arlen;
  - nbytes = 1<<arsize;
  - start lane = araddr[LB-1:0] & ~(nbytes-1);
  - clear the rdata buffer.
- Read error checks:
  - arlen != 0 or arsize > LB: go to RERR with SLVERR;
  - unmapped: go to RERR with DECERR.
- RERR: emit arlen+1 beats with rdata = 0 and rlast on the final beat, each beat waiting for rready.
- RREQ/RRSP:
  - mirror WREQ/WRSP with req_read = 1 and req_dat = 0;
  - each response byte lands in its own lane of the buffer; other lanes stay 0;
  - the lane counter increments until nbytes bytes are done, then go to RRESP.
- RRESP: rvalid = 1, rlast = 1, rresp OKAY, held stable until rready, then go to IDLE.
- Only one transaction is in flight at any time. awready/arready are never asserted outside IDLE.
- rsp_vld arriving on a non-selected channel is ignored; rsp_rdy for that channel stays 0.

Test Plan:
- Write 0x1FFF0_010 (ch1), awlen 0, wstrb 16'h0024, wdata lanes2=0xA5, 5=0x3C → two requests on ch1 in order: addr 2/dat 0xA5, then addr 5/dat 0x3C; then one B with bresp 00 and the original bid.
- Read ch0 at araddr low nibble 4, arsize 2 → four read requests, addr 4,5,6,7; rsp bytes 11,22,33,44 → rdata[63:32] = 0x44332211, other bits 0, rlast = 1.
- awvalid/wvalid and arvalid asserted together for three consecutive transactions → grant order is write, read, write.
- arlen = 3 to an unmapped address → four R beats with rresp 11, rlast only on the 4th; zero downstream requests.
- awlen = 1, wstrb 0 → awready, W drained through the wlast beat, B with SLVERR; write with wstrb 0 to a mapped channel → B OKAY, no requests.
- areset asserted during WRSP with req_rdy low → next cycle all outputs 0, FSM IDLE; a new read then completes normally.
